// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester holds the current grant
//   req_t   : request payload presented to the grant latch
package mem_arb_pkg;

  localparam int unsigned DATA_W              = 32;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Requester-side bus of the unified memory arbiter.
//   master : fetch/MEM stages (drive requests, receive ready/rdata/freezes)
//   slave  : arbiter
interface unified_mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        freeze_if;
  logic        freeze_pipe;

  modport master (
    output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe
  );

  modport slave (
    input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe
  );

endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter that sequences the SRAM wait states.
//   load/load_val : preset the count (wins over dec)
//   dec           : decrement, saturating at zero
//   zero_c        : count is zero
module wait_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port word SRAM between instruction fetch and the MEM
// stage; data has fixed priority, each access takes WAIT_CYCLES SRAM cycles
// plus one response cycle, and the freeze outputs hold the pipeline meanwhile.
//   clk, rst            : clock, async active-high reset
//   bus (slave)         : fetch/data requests, ready pulses, rdata, freezes
//   sram_en/we/addr/wdata : registered SRAM controls
//   sram_rdata          : SRAM read data, valid the cycle after a read cycle
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES) + 1;

  state_t            state;
  owner_t            owner;
  logic [DATA_W-1:0] rdata_q;
  logic              if_ready_q;
  logic              mem_ready_q;

  logic              data_req_c;
  logic              any_req_c;
  req_t              grant_req_c;
  logic              cnt_zero_c;
  logic              freeze_pipe_c;

  assign data_req_c = bus.mem_rd_en | bus.mem_wr_en;
  assign any_req_c  = data_req_c | bus.if_req;

  // Payload of the winning requester; data beats fetch. With rd and wr both
  // set, mem_wr_en alone decides the op, so the write takes effect.
  always_comb begin
    grant_req_c = '{we: 1'b0, addr: bus.if_addr, wdata: '0};
    if (data_req_c) begin
      grant_req_c = '{we: bus.mem_wr_en, addr: bus.mem_addr, wdata: bus.mem_wdata};
    end
  end

  // Byte-offset and above-depth address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{grant_req_c.addr[DATA_W-1:ADDR_W+2], grant_req_c.addr[1:0]};

  wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == ST_IDLE) && any_req_c),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .dec      (state == ST_ACCESS),
    .zero_c   (cnt_zero_c)
  );

  // Arbitration FSM with grant/operand latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_INST;
      sram_en     <= 1'b0;
      sram_we     <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      rdata_q     <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req_c) begin
            owner      <= data_req_c ? OWN_DATA : OWN_INST;
            sram_en    <= 1'b1;
            sram_we    <= grant_req_c.we;
            sram_addr  <= grant_req_c.addr[ADDR_W+1:2];
            sram_wdata <= grant_req_c.wdata;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_zero_c) begin
            rdata_q     <= sram_rdata;
            sram_en     <= 1'b0;
            sram_we     <= 1'b0;
            if_ready_q  <= (owner == OWN_INST);
            mem_ready_q <= (owner == OWN_DATA);
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.if_rdata  = rdata_q;
  assign bus.mem_rdata = rdata_q;

  // Freezes drop in the ready cycle so the pipeline advances on its closing edge.
  assign freeze_pipe_c   = data_req_c & ~mem_ready_q;
  assign bus.freeze_pipe = freeze_pipe_c;
  assign bus.freeze_if   = freeze_pipe_c | (bus.if_req & ~if_ready_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (ADDR_W=10, WAIT_CYCLES=3) with a
// behavioural single-port SRAM. Cycle 0 is the IDLE cycle a request is
// presented in; outputs are sampled 2 time units after each rising edge.
module tb_unified_mem_arbiter;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  logic [31:0]       sram_mem [0:(1<<ADDR_W)-1];
  logic              pl_we;
  logic [ADDR_W-1:0] pl_addr;
  logic [31:0]       pl_data;

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered read, plus a bench preload port.
  always @(posedge clk) begin
    if (pl_we) begin
      sram_mem[pl_addr] <= pl_data;
    end else if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_we   = 1'b0;
  endtask

  initial begin
    logic [31:0] bb_data [0:2];
    bb_data[0] = 32'hCAFE0001;
    bb_data[1] = 32'hCAFE0002;
    bb_data[2] = 32'hCAFE0003;

    rst = 1'b1;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    sram_rdata = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
    bus.mem_addr = '0; bus.mem_wdata = '0;

    preload(10'h010, 32'hE3A01005);
    preload(10'h011, 32'h11111111);
    preload(10'h012, 32'h22222222);
    preload(10'h000, 32'hA5A5A5A5);
    preload(10'h040, bb_data[0]);
    preload(10'h041, bb_data[1]);
    preload(10'h042, bb_data[2]);

    // Reset state
    #1;
    chk1 ("rst_sram_en",   sram_en, 1'b0);
    chk1 ("rst_sram_we",   sram_we, 1'b0);
    chk32("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk1 ("rst_if_ready",  bus.if_ready, 1'b0);
    chk1 ("rst_mem_ready", bus.mem_ready, 1'b0);
    chk32("rst_rdata",     bus.if_rdata, 32'h0);
    chk1 ("rst_freeze_if", bus.freeze_if, 1'b0);
    tick();
    rst = 1'b0;

    // Fetch only
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    #1;
    chk1("f_c0_freeze_if", bus.freeze_if, 1'b1);
    chk1("f_c0_sram_en",   sram_en, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick(); #1;
      chk1 ("f_acc_sram_en",   sram_en, 1'b1);
      chk1 ("f_acc_sram_we",   sram_we, 1'b0);
      chk32("f_acc_sram_addr", 32'(sram_addr), 32'h10);
      chk1 ("f_acc_if_ready",  bus.if_ready, 1'b0);
      chk1 ("f_acc_freeze_if", bus.freeze_if, 1'b1);
    end
    tick(); #1;
    chk1 ("f_c4_if_ready",  bus.if_ready, 1'b1);
    chk32("f_c4_if_rdata",  bus.if_rdata, 32'hE3A01005);
    chk1 ("f_c4_freeze_if", bus.freeze_if, 1'b0);
    chk1 ("f_c4_sram_en",   sram_en, 1'b0);
    bus.if_req = 1'b0;
    tick(); #1;
    chk1("f_c5_if_ready", bus.if_ready, 1'b0);
    chk1("f_c5_sram_en",  sram_en, 1'b0);

    // Write 0xDEADBEEF to 0x84
    bus.mem_wr_en = 1'b1; bus.mem_addr = 32'h84; bus.mem_wdata = 32'hDEADBEEF;
    #1;
    chk1("w_c0_freeze_pipe", bus.freeze_pipe, 1'b1);
    chk1("w_c0_freeze_if",   bus.freeze_if, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick(); #1;
      chk1 ("w_acc_sram_we",    sram_we, 1'b1);
      chk32("w_acc_sram_addr",  32'(sram_addr), 32'h21);
      chk32("w_acc_sram_wdata", sram_wdata, 32'hDEADBEEF);
      chk1 ("w_acc_freeze_pipe", bus.freeze_pipe, 1'b1);
    end
    tick(); #1;
    chk1("w_c4_mem_ready",   bus.mem_ready, 1'b1);
    chk1("w_c4_freeze_pipe", bus.freeze_pipe, 1'b0);
    chk1("w_c4_sram_we",     sram_we, 1'b0);
    bus.mem_wr_en = 1'b0;
    chk32("w_sram_word", sram_mem[10'h021], 32'hDEADBEEF);

    // Read back 0x84
    tick();
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h84;
    #1;
    chk1("r_c0_freeze_pipe", bus.freeze_pipe, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick(); #1;
      chk1("r_acc_sram_en", sram_en, 1'b1);
      chk1("r_acc_sram_we", sram_we, 1'b0);
    end
    tick(); #1;
    chk1 ("r_c4_mem_ready",   bus.mem_ready, 1'b1);
    chk32("r_c4_mem_rdata",   bus.mem_rdata, 32'hDEADBEEF);
    chk1 ("r_c4_freeze_pipe", bus.freeze_pipe, 1'b0);
    bus.mem_rd_en = 1'b0;

    // Conflict: fetch 0x44 and data read 0x84 together
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h84;
    #1;
    chk1("c_c0_freeze_if", bus.freeze_if, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      tick(); #1;
      chk1("c_freeze_if", bus.freeze_if, 1'b1);
      if (c == 4) begin
        chk1 ("c_c4_mem_ready", bus.mem_ready, 1'b1);
        chk32("c_c4_mem_rdata", bus.mem_rdata, 32'hDEADBEEF);
        chk1 ("c_c4_if_ready",  bus.if_ready, 1'b0);
        bus.mem_rd_en = 1'b0;
        #1;
        chk1("c_c4_freeze_if_after_drop", bus.freeze_if, 1'b1);
      end else begin
        chk1("c_if_ready_low",  bus.if_ready, 1'b0);
        chk1("c_mem_ready_low", bus.mem_ready, 1'b0);
      end
      if (c >= 6) chk32("c_inst_sram_addr", 32'(sram_addr), 32'h11);
    end
    tick(); #1;
    chk1 ("c_c9_if_ready",  bus.if_ready, 1'b1);
    chk32("c_c9_if_rdata",  bus.if_rdata, 32'h11111111);
    chk1 ("c_c9_freeze_if", bus.freeze_if, 1'b0);
    bus.if_req = 1'b0;

    // Reset in cycle 2 of a fetch from 0x48
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h48;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk1 ("rm_sram_en",   sram_en, 1'b0);
    chk1 ("rm_sram_we",   sram_we, 1'b0);
    chk32("rm_sram_addr", 32'(sram_addr), 32'h0);
    chk1 ("rm_if_ready",  bus.if_ready, 1'b0);
    chk32("rm_if_rdata",  bus.if_rdata, 32'h0);
    chk1 ("rm_freeze_if", bus.freeze_if, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk1("rm_idle_sram_en", sram_en, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick(); #1;
      chk1 ("rm_acc_sram_en",   sram_en, 1'b1);
      chk32("rm_acc_sram_addr", 32'(sram_addr), 32'h12);
    end
    tick(); #1;
    chk1 ("rm_if_ready_pulse", bus.if_ready, 1'b1);
    chk32("rm_if_rdata_val",   bus.if_rdata, 32'h22222222);
    bus.if_req = 1'b0;

    // Address wrap: 0x1000 maps to word 0
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    tick(); #1;
    chk32("wrap_sram_addr", 32'(sram_addr), 32'h0);
    tick(); tick(); tick(); #1;
    chk1 ("wrap_if_ready", bus.if_ready, 1'b1);
    chk32("wrap_if_rdata", bus.if_rdata, 32'hA5A5A5A5);
    bus.if_req = 1'b0;

    // Back-to-back fetches 0x100, 0x104, 0x108
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      for (int c = 1; c <= 3; c++) begin
        tick(); #1;
        chk1("bb_busy_if_ready", bus.if_ready, 1'b0);
      end
      tick(); #1;
      chk1 ("bb_if_ready", bus.if_ready, 1'b1);
      chk32("bb_if_rdata", bus.if_rdata, bb_data[i]);
      if (i < 2) begin
        bus.if_addr = bus.if_addr + 32'd4;
        tick(); #1;
        chk1("bb_idle_if_ready", bus.if_ready, 1'b0);
        chk1("bb_idle_sram_en",  sram_en, 1'b0);
      end else begin
        bus.if_req = 1'b0;
      end
    end
    tick(); #1;
    chk1("end_freeze_if", bus.freeze_if, 1'b0);
    chk1("end_sram_en",   sram_en, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
